// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store requester and dmem_responder.
// master: the requester side; slave: the responder side.
interface dmem_responder_if #(
    parameter int DEPTH_LOG2 = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DEPTH_LOG2+1:0] req_addr;
    logic [1:0]            req_width;
    logic                  req_zext;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_width, req_zext, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_width, req_zext, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-port word memory answering byte/halfword/word
// loads and stores one at a time over a valid/ready request/response pair.
// Sub-word stores are read-merge-write. Array contents are never reset.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned / reserved-width accesses respond with resp_err = 1
//   undefined -> such accesses are silent no-ops, resp_err tied to 0
//
// state | meaning
// IDLE  | ready for a request (only state with req_ready = 1)
// RD    | array word read: load extract, or old word fetched for a sub-word merge
// WR    | merged / full word written to the array on this edge
// RESP  | response held until resp_ready
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_write;
    logic [DEPTH_LOG2+1:0] r_addr;
    logic [1:0]            r_width;
    logic                  r_zext;
    logic [15:0]           r_wdata;
    logic [31:0]           r_merge;
    logic [31:0]           r_rdata;

    logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];

    logic                  w_accept;
    logic                  w_in_legal;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [1:0]            w_tail;
    logic [31:0]           w_word;
    logic [31:0]           w_load;
    logic [31:0]           w_merge;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;

    // Byte at any tail, halfword on even tails, word only at tail 00.
    function automatic logic is_legal(input logic [1:0] width, input logic [1:0] tail);
        logic ok;
        ok = 1'b0;
        case (width)
            2'b01:   ok = 1'b1;
            2'b10:   ok = (tail[0] == 1'b0);
            2'b11:   ok = (tail == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_accept   = bus.req_valid && (r_state == IDLE);
    assign w_in_legal = is_legal(bus.req_width, bus.req_addr[1:0]);

    // The word index is just the upper address bits, so addresses wrap naturally.
    assign w_idx  = r_addr[DEPTH_LOG2+1:2];
    assign w_tail = r_addr[1:0];
    assign w_word = r_mem[w_idx];

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: illegal -> RESP, word store -> WR, everything else reads first.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_in_legal) begin
                        w_next = RESP;
                    end else if (bus.req_write && (bus.req_width == 2'b11)) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD:      w_next = r_write ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = bus.resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // Load lane extraction and extension from the addressed word.
    always_comb begin
        w_load = w_word;
        w_byte = w_word[{w_tail, 3'b000} +: 8];
        w_half = w_tail[1] ? w_word[31:16] : w_word[15:0];
        case (r_width)
            2'b01:   w_load = r_zext ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b10:   w_load = r_zext ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // Sub-word store: new lanes laid over the old word.
    always_comb begin
        w_merge = w_word;
        case (r_width)
            2'b01: w_merge[{w_tail, 3'b000} +: 8] = r_wdata[7:0];
            2'b10: begin
                if (w_tail[1]) begin
                    w_merge[31:16] = r_wdata;
                end else begin
                    w_merge[15:0] = r_wdata;
                end
            end
            default: w_merge = w_word;
        endcase
    end

    // Request capture, load result and merge word. r_merge doubles as the
    // write-back word: loaded straight from req_wdata for full-word stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_width <= 2'b00;
            r_zext  <= 1'b0;
            r_wdata <= '0;
            r_merge <= '0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_width <= bus.req_width;
            r_zext  <= bus.req_zext;
            r_wdata <= bus.req_wdata[15:0];
            r_merge <= bus.req_wdata;
            r_rdata <= '0;
        end else if (r_state == RD) begin
            if (r_write) begin
                r_merge <= w_merge;
            end else begin
                r_rdata <= w_load;
            end
        end
    end

    // Array write; a reset before this edge forces IDLE so the word is kept.
    always_ff @(posedge clk) begin
        if (r_state == WR) begin
            r_mem[w_idx] <= r_merge;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_err;

    // Error flag latched at acceptance and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= !w_in_legal;
        end
    end

    assign bus.resp_err = r_err;
`else
    assign bus.resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a random
// phase checked against a small byte-lane memory model, via an expected queue.
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [31:0] tb_mem [0:255];

    dmem_responder_if #(.DEPTH_LOG2(8)) bus ();

    dmem_responder #(.DEPTH_LOG2(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1);
    end

    // Reference: size in bytes, alignment by modulo, lanes handled one byte at a time.
    task automatic model(input logic wr, input logic [9:0] addr, input logic [1:0] width,
                         input logic zext, input logic [31:0] wdata, output exp_t e);
        int nb;
        int t;
        logic [31:0] w;
        logic [31:0] v;
        nb = (width == 2'd1) ? 1 : (width == 2'd2) ? 2 : (width == 2'd3) ? 4 : 0;
        t  = int'(addr[1:0]);
        e.rdata = 32'h0;
        e.err   = 1'b0;
        if (nb == 0 || (t % nb) != 0) begin
            e.err = TRAP;
            e.lat = 1;
        end else if (wr) begin
            w = tb_mem[addr[9:2]];
            for (int i = 0; i < nb; i++) w[8*(t+i) +: 8] = wdata[8*i +: 8];
            tb_mem[addr[9:2]] = w;
            e.lat = (nb == 4) ? 2 : 3;
        end else begin
            v = 32'h0;
            w = tb_mem[addr[9:2]];
            for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(t+i) +: 8];
            if (!zext && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
            e.lat = 2;
        end
    endtask

    // Issue one request, push its expectation, then collect and check the response.
    task automatic access(input logic wr, input logic [9:0] addr, input logic [1:0] width,
                          input logic zext, input logic [31:0] wdata, input exp_t ein,
                          input int hold, input string name);
        exp_t e;
        int cyc;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_width = width;
        bus.req_zext  = zext;
        bus.req_wdata = wdata;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_ready at issue: got %b want 1", name, bus.req_ready);
        end
        exp_q.push_back(ein);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.resp_valid !== 1'b1 && cyc < 20);
        e = exp_q.pop_front();
        n_checks++;
        if (bus.resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s resp timeout: got no resp_valid after %0d cycles want %0d", name, cyc, e.lat);
            return;
        end
        if (cyc != e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
        end
        n_checks++;
        if (bus.resp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got %08h want %08h", name, bus.resp_rdata, e.rdata);
        end
        n_checks++;
        if (bus.resp_err !== e.err) begin
            n_fail++;
            $display("FAIL %s err: got %b want %b", name, bus.resp_err, e.err);
        end
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s req_ready in RESP: got %b want 0", name, bus.req_ready);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata ||
                bus.resp_err !== e.err || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold %0d: got v=%b d=%08h e=%b rdy=%b want v=1 d=%08h e=%b rdy=0",
                         name, h, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready,
                         e.rdata, e.err);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        n_checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after consume: got v=%b rdy=%b want v=0 rdy=1",
                     name, bus.resp_valid, bus.req_ready);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic er, input int lat);
        exp_t e;
        e.rdata = d;
        e.err   = er;
        e.lat   = lat;
        return e;
    endfunction

    task automatic test_reset();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_width  = 2'b00;
        bus.req_zext   = 1'b0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
            bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdy=%b v=%b d=%08h e=%b want 1 0 00000000 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_word_store_load();
        access(1'b1, 10'h010, 2'b11, 1'b0, 32'hDEADBEEF, mk(32'h0, 1'b0, 2), 0, "word_store");
        access(1'b0, 10'h010, 2'b11, 1'b0, 32'h0, mk(32'hDEADBEEF, 1'b0, 2), 0, "word_load");
    endtask

    task automatic test_byte_store();
        access(1'b1, 10'h013, 2'b01, 1'b0, 32'h0000005A, mk(32'h0, 1'b0, 3), 0, "byte_store");
        access(1'b0, 10'h010, 2'b11, 1'b0, 32'h0, mk(32'h5AADBEEF, 1'b0, 2), 0, "merged_word");
        access(1'b0, 10'h013, 2'b01, 1'b0, 32'h0, mk(32'h0000005A, 1'b0, 2), 0, "byte_load");
        access(1'b1, 10'h012, 2'b10, 1'b0, 32'hFFFF1234, mk(32'h0, 1'b0, 3), 0, "half_store_hi");
        access(1'b0, 10'h010, 2'b11, 1'b0, 32'h0, mk(32'h1234BEEF, 1'b0, 2), 0, "half_merged");
    endtask

    task automatic test_extend();
        access(1'b1, 10'h020, 2'b11, 1'b0, 32'h80FF7F01, mk(32'h0, 1'b0, 2), 0, "ext_store");
        access(1'b0, 10'h022, 2'b01, 1'b0, 32'h0, mk(32'hFFFFFFFF, 1'b0, 2), 0, "byte_sext");
        access(1'b0, 10'h022, 2'b10, 1'b1, 32'h0, mk(32'h000080FF, 1'b0, 2), 0, "half_zext");
        access(1'b0, 10'h020, 2'b10, 1'b0, 32'h0, mk(32'h00007F01, 1'b0, 2), 0, "half_sext_pos");
        access(1'b0, 10'h022, 2'b10, 1'b0, 32'h0, mk(32'hFFFF80FF, 1'b0, 2), 0, "half_sext_neg");
        access(1'b0, 10'h021, 2'b01, 1'b1, 32'h0, mk(32'h0000007F, 1'b0, 2), 0, "byte_tail1");
    endtask

    task automatic test_illegal();
        access(1'b0, 10'h021, 2'b10, 1'b0, 32'h0, mk(32'h0, TRAP, 1), 0, "half_misalign_ld");
        access(1'b1, 10'h022, 2'b11, 1'b0, 32'h12345678, mk(32'h0, TRAP, 1), 0, "word_misalign_st");
        access(1'b1, 10'h020, 2'b00, 1'b0, 32'h12345678, mk(32'h0, TRAP, 1), 0, "width00_st");
        access(1'b1, 10'h023, 2'b10, 1'b0, 32'h00005555, mk(32'h0, TRAP, 1), 0, "half_tail3_st");
        access(1'b0, 10'h020, 2'b11, 1'b0, 32'h0, mk(32'h80FF7F01, 1'b0, 2), 0, "after_illegal");
    endtask

    task automatic test_hold();
        access(1'b0, 10'h010, 2'b11, 1'b0, 32'h0, mk(32'h1234BEEF, 1'b0, 2), 5, "hold_load");
        access(1'b0, 10'h021, 2'b11, 1'b0, 32'h0, mk(32'h0, TRAP, 1), 5, "hold_illegal");
    endtask

    task automatic test_reset_mid();
        access(1'b1, 10'h030, 2'b11, 1'b0, 32'h11223344, mk(32'h0, 1'b0, 2), 0, "rst_setup");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 10'h031;
        bus.req_width = 2'b01;
        bus.req_zext  = 1'b0;
        bus.req_wdata = 32'h000000AA;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid in RD: got rdy=%b v=%b want 0 0", bus.req_ready, bus.resp_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
            bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid outputs: got rdy=%b v=%b d=%08h e=%b want 1 0 00000000 0",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 10'h030, 2'b11, 1'b0, 32'h0, mk(32'h11223344, 1'b0, 2), 0, "rst_mid_word");
    endtask

    task automatic test_random();
        exp_t e;
        logic [9:0]  a;
        logic [1:0]  w;
        logic        wr;
        logic        z;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            a = 10'h100 + 10'(i * 4);
            d = $urandom;
            model(1'b1, a, 2'b11, 1'b0, d, e);
            access(1'b1, a, 2'b11, 1'b0, d, e, 0, "rand_init");
        end
        for (int i = 0; i < 60; i++) begin
            a  = 10'h100 + 10'($urandom_range(0, 31));
            w  = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            d  = $urandom;
            model(wr, a, w, z, d, e);
            access(wr, a, w, z, d, e, (i % 7 == 0) ? 2 : 0, "rand");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_extend();
        test_illegal();
        test_hold();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
